// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   md_op_e     : RV32M funct3 operation encoding
//   mdu_state_e : control FSM states
//   is_div / is_rem / signed_a / signed_b : operation decode helpers
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic signed_a(input md_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic signed_b(input md_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/adder.sv
// Ripple-free behavioural WIDTH-bit adder with carry in/out.
// The single arithmetic element of the multiply/divide unit.
//   a, b : addends
//   cin  : carry in (set with an inverted b to subtract / negate)
//   sum  : low WIDTH bits of a + b + cin
//   cout : carry out (1 = no borrow when subtracting)
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide). One operation at a time through a start/busy
// handshake; fixed latency of WIDTH+1 edges from accept to done.
// All arithmetic goes through one time-shared adder instance.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted when busy=0 and flush=0
//   op       : RV32M funct3 operation
//   a, b     : rs1 / rs2 operands
//   flush    : abort any in-flight operation (no done, result kept)
//   busy     : operation in flight
//   done     : one-cycle pulse, result valid
//   result   : result, held until the next done
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  md_op_e           op_in, op_q;
  logic             accept;
  logic             sign_a, sign_b, div_zero, div_ovf, seen_one;
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [WIDTH-1:0] shifted, a_mag;
  logic             div_ok, mul_bit;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic [WIDTH-1:0] fix_val, fix_out;
  logic             fix_neg, fix_cin;

  // Divide-by-zero and signed-overflow results replace the computed value.
  // REM/REMU by zero need no override: with a zero divisor every trial
  // subtract commits unchanged, so the remainder already equals a.
  function automatic logic [WIDTH-1:0] special_result(
    input md_op_e           o,
    input logic             dz,
    input logic             ovf,
    input logic [WIDTH-1:0] val
  );
    if (dz && !is_rem(o)) return '1;
    if (ovf) return is_rem(o) ? '0 : MIN_NEG;
    return val;
  endfunction

  assign op_in  = md_op_e'(op);
  assign accept = (state == IDLE) && start && !flush;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = CALC;
        CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
        FIX:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Partial remainder shifted left with the next dividend bit. Its lost MSB
  // makes it exceed any WIDTH-bit divisor, so the trial subtract succeeds.
  assign shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
  assign div_ok  = add_cout | hi[WIDTH-1];

  // A negative multiplier is negated serially, LSB first: bits are copied up
  // to and including the first 1, and inverted after it.
  assign mul_bit = lo[0] ^ (sign_b & seen_one);

  // In IDLE the adder negates the incoming a.
  assign a_mag = (signed_a(op_in) && a[WIDTH-1]) ? add_sum : a;

  always_comb begin
    fix_val = hi;
    fix_neg = sign_a ^ sign_b;
    fix_cin = 1'b1;
    case (op_q)
      OP_MUL, OP_DIV, OP_DIVU:      fix_val = lo;
      // high word of a negated 2*WIDTH product: carry in only if low word is 0
      OP_MULH, OP_MULHSU, OP_MULHU: fix_cin = (lo == '0);
      OP_REM, OP_REMU:              fix_neg = sign_a;
      default: ;
    endcase
  end

  always_comb begin
    add_a   = '0;
    add_b   = ~a;
    add_cin = 1'b1;
    case (state)
      CALC: begin
        if (is_div(op_q)) begin
          // signed divisor is kept raw: rem + b equals rem - |b| when b < 0
          add_a   = shifted;
          add_b   = sign_b ? opnd : ~opnd;
          add_cin = ~sign_b;
        end else begin
          add_a   = hi;
          add_b   = opnd;
          add_cin = 1'b0;
        end
      end
      FIX: begin
        add_a   = '0;
        add_b   = ~fix_val;
        add_cin = fix_cin;
      end
      default: ;
    endcase
  end

  assign fix_out = special_result(op_q, div_zero, div_ovf, fix_neg ? add_sum : fix_val);

  // Accept: capture operands as magnitudes
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q     <= op_in;
      sign_a   <= signed_a(op_in) & a[WIDTH-1];
      sign_b   <= signed_b(op_in) & b[WIDTH-1];
      div_zero <= is_div(op_in) && (b == '0);
      div_ovf  <= ((op_in == OP_DIV) || (op_in == OP_REM)) && (a == MIN_NEG) && (b == '1);
      seen_one <= 1'b0;
      hi       <= '0;
      if (is_div(op_in)) begin
        lo   <= a_mag;
        opnd <= b;
      end else begin
        lo   <= b;
        opnd <= a_mag;
      end
    // Iterate: one multiplier bit or one quotient bit per cycle
    end else if (state == CALC) begin
      if (is_div(op_q)) begin
        hi <= div_ok ? add_sum : shifted;
        lo <= {lo[WIDTH-2:0], div_ok};
      end else begin
        seen_one <= seen_one | lo[0];
        if (mul_bit) {hi, lo} <= {add_cout, add_sum, lo[WIDTH-1:1]};
        else         {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
      end
    end
  end

  // Sign fix and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush)              cnt <= '0;
      else if (accept)        cnt <= CNT_W'(WIDTH);
      else if (state == CALC) cnt <= cnt - CNT_W'(1);
      if ((state == FIX) && !flush) begin
        done   <= 1'b1;
        result <= fix_out;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int WIDTH  = 32;
  localparam int LAT    = WIDTH + 1;
  localparam int SEED   = 1;
  localparam int N_RAND = 1000;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int accepts = 0;
  int drops = 0;
  int dones = 0;
  bit chk_en = 1'b0;

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_exp = '0;
  int          m_left = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     p;
    int              ix, iy;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    ix = x;
    iy = y;
    case (o)
      MUL:    begin p = ux * uy; return p[31:0];  end
      MULH:   begin p = sx * sy; return p[63:32]; end
      MULHSU: begin p = sx * uy; return p[63:32]; end
      MULHU:  begin p = ux * uy; return p[63:32]; end
      DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ix / iy;
      end
      DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
      REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        return ix % iy;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Transaction-level reference: an accepted op yields its result LAT edges later.
  always @(posedge clk) begin
    if (rst) begin
      if (m_busy) drops <= drops + 1;
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else begin
      m_done <= 1'b0;
      if (flush) begin
        if (m_busy) drops <= drops + 1;
        m_busy <= 1'b0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_exp;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_busy  <= 1'b1;
        m_left  <= LAT;
        m_exp   <= ref_md(op, a, b);
        accepts <= accepts + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk(busy === m_busy, "cyc_busy", 32'(busy), 32'(m_busy));
      chk(done === m_done, "cyc_done", 32'(done), 32'(m_done));
      chk(result === m_result, "cyc_result", result, m_result);
      if (done === 1'b1) dones++;
    end
  end

  // Starts from a negedge, returns at the negedge of the done cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input bit pin, input int poke, input string nm);
    int n;
    int e0;
    if (pin) chk(ref_md(o, x, y) === exp, {nm, "_model"}, ref_md(o, x, y), exp);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(busy === 1'b0, {nm, "_idle"}, 32'(busy), 32'd0);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = edge_cnt;
    chk(busy === 1'b1, {nm, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (done !== 1'b1 && n < LAT + 8) begin
      @(negedge clk);
      n++;
      if (poke != 0 && n == poke) begin
        op = DIVU;
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk(done === 1'b1, {nm, "_done"}, 32'(done), 32'd1);
    chk(edge_cnt - e0 == LAT, {nm, "_lat"}, 32'(edge_cnt - e0), 32'(LAT));
    chk(result === exp, {nm, "_res"}, result, exp);
    chk(busy === 1'b0, {nm, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t want earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int nd;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    void'($urandom(SEED));
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "rst_done", 32'(done), 32'd0);
    chk(result === 32'd0, "rst_result", result, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    do_op(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 0, "mul");
    do_op(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b1, 0, "mulh_min");
    do_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 0, "mulhu");
    do_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "mulhsu");
    do_op(MULH,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 1'b1, 0, "mulh_m1");
    do_op(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b1, 0, "div_neg");
    do_op(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b1, 0, "rem_neg");
    do_op(DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1, 0, "div_negb");
    do_op(REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         1'b1, 0, "rem_negb");
    do_op(DIVU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,         1'b1, 0, "divu_big");
    do_op(REMU,   32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'd1,         1'b1, 0, "remu_big");
    do_op(DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 0, "div_z");
    do_op(REM,    32'd5,          32'd0,         32'd5,         1'b1, 0, "rem_z");
    do_op(DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1'b1, 0, "div_negz");
    do_op(REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1'b1, 0, "rem_negz");
    do_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 0, "div_ovf");
    do_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1, 0, "rem_ovf");

    // start while busy is dropped, not queued
    do_op(MULHU,  32'h0001_0000,  32'h0003_0000, 32'd3,         1'b1, 5, "poke");
    nd = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk(nd == 0, "poke_no_extra_done", 32'(nd), 32'd0);

    // back-to-back: second start in the done cycle
    do_op(DIVU, 32'd100, 32'd7, 32'd14, 1'b1, 0, "divu");
    t0 = edge_cnt;
    do_op(REMU, 32'd100, 32'd7, 32'd2,  1'b1, 0, "remu_b2b");
    chk(edge_cnt - t0 == LAT + 1, "b2b_gap", 32'(edge_cnt - t0), 32'(LAT + 1));

    // flush in the done cycle leaves result alone
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk(result === 32'd2, "flush_done_cycle_res", result, 32'd2);

    // flush mid-multiply
    op = MUL;
    a = 32'd3;
    b = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk(busy === 1'b0, "flush_busy", 32'(busy), 32'd0);
    chk(result === 32'd2, "flush_res", result, 32'd2);
    nd = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk(nd == 0, "flush_no_done", 32'(nd), 32'd0);

    // flush and start together: start dropped
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    chk(busy === 1'b0, "flush_start_busy", 32'(busy), 32'd0);

    // reset mid-divide
    op = DIV;
    a = 32'hFFFF_FFF9;
    b = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(busy === 1'b0, "midrst_busy", 32'(busy), 32'd0);
    chk(done === 1'b0, "midrst_done", 32'(done), 32'd0);
    chk(result === 32'd0, "midrst_result", result, 32'd0);

    for (int i = 0; i < N_RAND; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick();
      rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
      do_op(ro, ra, rb, ref_md(ro, ra, rb), 1'b0, 0, "rnd");
    end

    repeat (3) @(negedge clk);
    chk(dones + drops == accepts, "done_count", 32'(dones + drops), 32'(accepts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
